// File: rtl/gpr_pkg.sv
// Shared widths and the writeback source encoding for the GPR writeback path.
package gpr_pkg;
  localparam int GPR_ADDR_W = 5;
  localparam int GPR_DATA_W = 32;
  localparam int GPR_NUM    = 32;

  typedef enum logic {
    WB_EXU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;
endpackage

// File: rtl/gpr_wb_arbiter_scoreboard.sv
// GPR busy tracking: one pending-result bit per register plus the issue hazard check.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     chk_valid,
  input  logic                     set_en,
  input  logic [ADDR_WIDTH-1:0]    set_idx,
  input  logic                     clr_en,
  input  logic [ADDR_WIDTH-1:0]    clr_idx,
  input  logic [ADDR_WIDTH-1:0]    rs1,
  input  logic [ADDR_WIDTH-1:0]    rs2,
  output logic                     stall,
  output logic [2**ADDR_WIDTH-1:0] busy_vec
);
  localparam int N = 2**ADDR_WIDTH;

  logic [N-1:0] busy_q;
  logic [N-1:0] busy_d;
  logic         set_ok;

  // set_en qualifies both the WAW check on set_idx and the scoreboard set.
  assign stall  = chk_valid && (busy_q[rs1] || busy_q[rs2] || (set_en && busy_q[set_idx]));
  assign set_ok = chk_valid && set_en && !stall && (set_idx != '0);

  // Clear first, then set, so a new producer keeps ownership of the register.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_ok) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin merge of EXU and LSU writebacks onto the single GPR write port,
// with the registered commit stage feeding the scoreboard clear.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_W,
  parameter int DATA_WIDTH = GPR_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exu_valid,
  output logic                     exu_ready,
  input  logic [ADDR_WIDTH-1:0]    exu_rd,
  input  logic [DATA_WIDTH-1:0]    exu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  input  logic                     issue_valid,
  input  logic                     issue_wr,
  input  logic [ADDR_WIDTH-1:0]    issue_rd,
  input  logic [ADDR_WIDTH-1:0]    issue_rs1,
  input  logic [ADDR_WIDTH-1:0]    issue_rs2,
  output logic                     issue_stall,
  output logic                     gpr_wen,
  output logic [ADDR_WIDTH-1:0]    gpr_waddr,
  output logic [DATA_WIDTH-1:0]    gpr_wdata,
  output logic [2**ADDR_WIDTH-1:0] busy_vec
);
  wb_src_e rr;

  assign exu_ready = exu_valid && (!lsu_valid || rr == WB_EXU);
  assign lsu_ready = lsu_valid && (!exu_valid || rr == WB_LSU);

  // Writes to x0 still handshake but never raise the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
      rr        <= WB_EXU;
    end else begin
      gpr_wen <= 1'b0;
      if (exu_ready) begin
        gpr_wen   <= (exu_rd != '0);
        gpr_waddr <= exu_rd;
        gpr_wdata <= exu_data;
        rr        <= WB_LSU;
      end else if (lsu_ready) begin
        gpr_wen   <= (lsu_rd != '0);
        gpr_waddr <= lsu_rd;
        gpr_wdata <= lsu_data;
        rr        <= WB_EXU;
      end
    end
  end

  gpr_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .chk_valid (issue_valid),
    .set_en    (issue_wr),
    .set_idx   (issue_rd),
    .clr_en    (gpr_wen),
    .clr_idx   (gpr_waddr),
    .rs1       (issue_rs1),
    .rs2       (issue_rs2),
    .stall     (issue_stall),
    .busy_vec  (busy_vec)
  );
endmodule
